// File: rtl/bcd_cascade_display.sv
// -----------------------------------------------------------------------------
// bcd_cascade_display
//
// Purpose:
//   Takes the units digit of an external decade counter and watches for its
//   9->0 wrap. Each wrap is cascaded into tens and hundreds BCD digits, which
//   gives a 000-999 count. That count drives a time-multiplexed 3-digit
//   seven-segment display. The display supports leading-zero blanking and a
//   freeze (hold). Sticky flags report count overflow and invalid units input.
//
// Parameters:
//   SCAN_DIV      - clk cycles each digit stays enabled (1..65535)
//   BLANK_LEADING - 1: blank leading zero digits (hundreds, then tens)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active low, overrides all other inputs
//   units    in   [3:0] BCD units digit from the decade counter
//   clear    in   synchronous clear of tens/hundreds/overflow/err
//   hold     in   1 = freeze the display latch (counting continues)
//   tens     out  [3:0] registered tens digit
//   hundreds out  [3:0] registered hundreds digit
//   overflow out  sticky, set on a 999->000 wrap
//   err      out  sticky, set when units > 9 is sampled
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active high
//   an       out  [2:0] one-hot digit enable (bit0 units, bit1 tens, bit2 hundreds)
// -----------------------------------------------------------------------------
module bcd_cascade_display #(
    parameter int unsigned SCAN_DIV      = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] units,
    input  logic       clear,
    input  logic       hold,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       overflow,
    output logic       err,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_ZERO = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b1000000;   // out-of-range digit shows "-"
        endcase
        return p;
    endfunction

    // Counting state
    logic [3:0]  u_s_q, u_s_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    // Display state. disp_*[0] = units, [1] = tens, [2] = hundreds.
    logic [3:0]  disp_q [3];
    logic [3:0]  disp_d [3];
    logic [15:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic        units_ok;
    logic        carry;

    assign units_ok = (units <= 4'd9);
    // The wrap is seen when the previous sample was 9 and the current one is 0.
    // Because the current input is compared, tens moves on the same edge that
    // u_s loads the 0.
    assign carry    = (u_s_q == 4'd9) && (units == 4'd0);

    always_comb begin
        u_s_d  = units_ok ? units : u_s_q;
        tens_d = tens_q;
        hund_d = hund_q;
        ovf_d  = ovf_q;
        err_d  = err_q | ~units_ok;

        if (carry) begin
            if (tens_q == 4'd9) begin
                tens_d = 4'd0;
                if (hund_q == 4'd9) begin
                    hund_d = 4'd0;
                    ovf_d  = 1'b1;
                end else begin
                    hund_d = hund_q + 4'd1;
                end
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end

        // clear wins over a simultaneous carry or error
        if (clear) begin
            tens_d = 4'd0;
            hund_d = 4'd0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end
    end

    // The latch samples the registered counters. This gives the
    // display a one-cycle lag behind the counters.
    always_comb begin
        if (hold) begin
            disp_d[0] = disp_q[0];
            disp_d[1] = disp_q[1];
            disp_d[2] = disp_q[2];
        end else begin
            disp_d[0] = u_s_q;
            disp_d[1] = tens_q;
            disp_d[2] = hund_q;
        end
    end

    // Per-digit pattern and blank decision, computed from the next latch
    // contents so that seg agrees with the latch value of the same cycle.
    logic [6:0] dig_seg [3];
    logic [2:0] dig_blank;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign dig_seg[gi] = seg7(disp_d[gi]);
        end
        if (BLANK_LEADING) begin : g_blank
            assign dig_blank[0] = 1'b0;
            assign dig_blank[1] = (disp_d[2] == 4'd0) && (disp_d[1] == 4'd0);
            assign dig_blank[2] = (disp_d[2] == 4'd0);
        end else begin : g_noblank
            assign dig_blank = 3'b000;
        end
    endgenerate

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q >= DIV_LAST) begin
            div_d = 16'd0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_d = div_q + 16'd1;
        end

        an_d  = 3'b001;
        seg_d = dig_blank[0] ? 7'b0000000 : dig_seg[0];
        case (idx_d)
            2'd1: begin
                an_d  = 3'b010;
                seg_d = dig_blank[1] ? 7'b0000000 : dig_seg[1];
            end
            2'd2: begin
                an_d  = 3'b100;
                seg_d = dig_blank[2] ? 7'b0000000 : dig_seg[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            u_s_q     <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            disp_q[0] <= 4'd0;
            disp_q[1] <= 4'd0;
            disp_q[2] <= 4'd0;
            div_q     <= 16'd0;
            idx_q     <= 2'd0;
            an_q      <= 3'b001;
            seg_q     <= SEG_ZERO;
        end else begin
            u_s_q     <= u_s_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            disp_q[0] <= disp_d[0];
            disp_q[1] <= disp_d[1];
            disp_q[2] <= disp_d[2];
            div_q     <= div_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign tens     = tens_q;
    assign hundreds = hund_q;
    assign overflow = ovf_q;
    assign err      = err_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_bcd_cascade_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_cascade_display
//
// Directed self-checking bench for bcd_cascade_display (SCAN_DIV=4).
// Instance dut has leading-zero blanking enabled. Instance dut0 has it
// disabled. Both instances share the same inputs.
// -----------------------------------------------------------------------------
module tb_bcd_cascade_display;

    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P5 = 7'b1101101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] PB = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] units = 4'd0;
    logic       clear = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] tens, hundreds, tens0, hundreds0;
    logic       overflow, err, overflow0, err0;
    logic [6:0] seg, seg0;
    logic [2:0] an, an0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_cascade_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .units(units), .clear(clear), .hold(hold),
        .tens(tens), .hundreds(hundreds), .overflow(overflow), .err(err),
        .seg(seg), .an(an)
    );

    bcd_cascade_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .reset(reset), .units(units), .clear(clear), .hold(hold),
        .tens(tens0), .hundreds(hundreds0), .overflow(overflow0), .err(err0),
        .seg(seg0), .an(an0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive units 1..9 then 0 (one wrap).
    task automatic wrap_once();
        for (int v = 1; v <= 10; v++) begin
            units = 4'(v % 10);
            step();
        end
    endtask

    // Step until an equals target, bounded; expiry counts as a failure.
    task automatic wait_an(input logic [2:0] target, input string name);
        int n;
        n = 0;
        while (an !== target && n < 16) begin
            step();
            n++;
        end
        chk({name, "_an_reached"}, {29'd0, an}, {29'd0, target});
    endtask

    typedef struct {
        logic [3:0] u;
        logic       clr;
        logic [3:0] e_tens;
        logic [3:0] e_hund;
        logic       e_ovf;
        logic       e_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Invalid-input and clear-priority vectors, starting from 000 with
        // u_s = 0 and both flags clear.
        vecs[0]  = '{4'd9,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1}; // err set, u_s stays 9
        vecs[2]  = '{4'd0,  1'b0, 4'd1, 4'd0, 1'b0, 1'b1}; // carry from held 9
        vecs[3]  = '{4'd5,  1'b0, 4'd1, 4'd0, 1'b0, 1'b1};
        vecs[4]  = '{4'd9,  1'b0, 4'd1, 4'd0, 1'b0, 1'b1};
        vecs[5]  = '{4'd0,  1'b1, 4'd0, 4'd0, 1'b0, 1'b0}; // clear beats carry
        vecs[6]  = '{4'd1,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0}; // u_s was 0: no carry
        vecs[7]  = '{4'd15, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
        vecs[8]  = '{4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1'b1}; // u_s=1 -> no carry
        vecs[9]  = '{4'd9,  1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{4'd12, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0}; // clear beats error
        vecs[11] = '{4'd0,  1'b0, 4'd1, 4'd0, 1'b0, 1'b0}; // u_s still 9 -> carry

        // ---------------- 1. reset ----------------
        reset = 1'b0;
        units = 4'd5;
        repeat (3) step();
        chk("rst_tens", {28'd0, tens}, 32'd0);
        chk("rst_hund", {28'd0, hundreds}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_an", {29'd0, an}, 32'd1);
        chk("rst_seg", {25'd0, seg}, {25'd0, P0});
        reset = 1'b1;
        step();
        chk("rel_seg_lag", {25'd0, seg}, {25'd0, P0});
        step();
        chk("rel_seg_units5", {25'd0, seg}, {25'd0, P5});
        chk("rel_an", {29'd0, an}, 32'd1);

        // ---------------- 2. cascade over 100 wraps ----------------
        units = 4'd0;
        step();
        chk("u5to0_nocarry", {28'd0, tens}, 32'd0);
        for (int w = 1; w <= 100; w++) begin
            for (int v = 1; v <= 9; v++) begin
                units = 4'(v);
                step();
            end
            chk($sformatf("pre_wrap%0d_tens", w), {28'd0, tens}, 32'((w - 1) % 10));
            units = 4'd0;
            step();
            chk($sformatf("wrap%0d_tens", w), {28'd0, tens}, 32'(w % 10));
            chk($sformatf("wrap%0d_hund", w), {28'd0, hundreds}, 32'((w / 10) % 10));
            chk($sformatf("wrap%0d_ovf", w), {31'd0, overflow}, (w == 100) ? 32'd1 : 32'd0);
        end
        units = 4'd9;
        step();
        units = 4'd9;
        step();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("u9to9_nocarry", {28'd0, tens}, 32'd0);
        units = 4'd0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_tens", {28'd0, tens}, 32'd0);

        // ---------------- 3. invalid input / clear priority (table) --------
        for (int i = 0; i < 12; i++) begin
            units = vecs[i].u;
            clear = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_tens", i), {28'd0, tens}, {28'd0, vecs[i].e_tens});
            chk($sformatf("vec%0d_hund", i), {28'd0, hundreds}, {28'd0, vecs[i].e_hund});
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
        end
        clear = 1'b0;

        // ---------------- 4. scan and blank, count 007 ----------------
        units = 4'd7;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        begin
            logic [2:0] prev_an;
            int n;
            n = 0;
            prev_an = an;
            step();
            while (!(an == 3'b001 && prev_an == 3'b100) && n < 20) begin
                prev_an = an;
                step();
                n++;
            end
            chk("scan_align", {29'd0, an}, 32'd1);
        end
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("scan_d%0d_k%0d_an", d, k), {29'd0, an}, 32'(1 << d));
                chk($sformatf("scan_d%0d_k%0d_seg", d, k), {25'd0, seg},
                    {25'd0, (d == 0) ? P7 : PB});
                chk($sformatf("noblank_d%0d_k%0d_seg", d, k), {25'd0, seg0},
                    {25'd0, (d == 0) ? P7 : P0});
                step();
            end
        end
        chk("scan_wrap_an", {29'd0, an}, 32'd1);

        // ---------------- 5. hold ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (4) wrap_once();
        units = 4'd1;
        step();
        units = 4'd2;
        step();
        step();
        hold = 1'b1;
        repeat (3) wrap_once();
        units = 4'd1;
        step();
        units = 4'd2;
        step();
        chk("hold_tens", {28'd0, tens}, 32'd7);
        chk("hold_hund", {28'd0, hundreds}, 32'd0);
        wait_an(3'b010, "hold_t");
        chk("hold_seg_tens4", {25'd0, seg}, {25'd0, P4});
        wait_an(3'b100, "hold_h");
        chk("hold_seg_hblank", {25'd0, seg}, {25'd0, PB});
        wait_an(3'b001, "hold_u");
        chk("hold_seg_units2", {25'd0, seg}, {25'd0, P2});
        hold = 1'b0;
        step();
        wait_an(3'b010, "rel_t");
        chk("rel_seg_tens7", {25'd0, seg}, {25'd0, P7});
        wait_an(3'b001, "rel_u");
        chk("rel_seg_units2", {25'd0, seg}, {25'd0, P2});

        // ---------------- 6. reset during carry at 099 ----------------
        clear = 1'b1;
        units = 4'd0;
        step();
        clear = 1'b0;
        repeat (9) wrap_once();
        for (int v = 1; v <= 9; v++) begin
            units = 4'(v);
            step();
        end
        chk("pre_rst_tens", {28'd0, tens}, 32'd9);
        chk("pre_rst_hund", {28'd0, hundreds}, 32'd0);
        units = 4'd0;
        reset = 1'b0;
        step();
        chk("midrst_tens", {28'd0, tens}, 32'd0);
        chk("midrst_hund", {28'd0, hundreds}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        chk("midrst_an", {29'd0, an}, 32'd1);
        chk("midrst_seg", {25'd0, seg}, {25'd0, P0});
        reset = 1'b1;
        units = 4'd0;
        step();
        chk("post_rst_nocarry", {28'd0, tens}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_display.md
Name: bcd_cascade_display

Overview:
Downstream consumer of the decade (mod-10) counter's 4-bit digit output.
- Detects each 9->0 wrap of that units digit and cascades it into tens and hundreds BCD digits, giving a 000-999 count.
- Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking, a display freeze and sticky overflow/error flags.
- Sits between the decade counter and the board display pins.

Parameters:
SCAN_DIV, 4, clk cycles each digit stays enabled before the scan advances; legal range 1..65535.
BLANK_LEADING, 1, 1 = blank leading zero digits (hundreds, then tens); 0 = show all digits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
units  input  4  BCD units digit from decade counter; synchronous to clk, expected range 0..9.
clear  input  1  synchronous clear of cascade digits and flags, active high.
hold  input  1  1 = freeze displayed value; counting continues.
tens  output  4  registered tens BCD digit.
hundreds  output  4  registered hundreds BCD digit.
overflow  output  1  sticky; set when the count wraps 999->000.
err  output  1  sticky; set when units > 9 is sampled.
seg  output  7  segment drive {g,f,e,d,c,b,a}, active high.
an  output  3  one-hot digit enable, active high; bit0 = units, bit1 = tens, bit2 = hundreds.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low, sampled on the rising edge of clk; it overrides every other input.
- Values while reset=0: u_s=0, tens=0, hundreds=0, overflow=0, err=0, display latch=000, scan divider=0, digit index=0, an=3'b001, seg=7'b0111111 (digit "0").
- u_s register: captures units every edge when units<=9. When units>9 it is not loaded, err is set, and no carry is generated.
- carry (combinational): (u_s==9) && (units==0). Evaluated on the same edge where u_s loads 0, so tens updates on that edge (1-cycle latency from units showing 0).
- Cascade on carry:
  - tens<9: tens+1.
  - tens==9: tens=0 and hundreds carries.
  - hundreds<9: hundreds+1.
  - hundreds==9: hundreds=0, overflow=1.
- Any other units transition (0->1, 9->9, 5->0, ...) produces no carry.
- clear=1 (reset=1): tens, hundreds, overflow and err go to 0 on that edge. clear beats a simultaneous carry or error. u_s, display latch and scan are not affected.
- Display latch {hundreds,tens,units}:
  - When hold=0, loads the post-edge values every cycle, so the display lags the counters by 1 cycle.
  - When hold=1, keeps its value.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the divider wraps to 0 and the digit index advances 0->1->2->0.
  - an and seg are registered and follow the index, so each digit stays enabled for exactly SCAN_DIV cycles.
- Decode: 0-9 use standard patterns (0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111). Latched values >9 decode to 1000000 ("-").
- Blanking (BLANK_LEADING=1):
  - Hundreds digit blank when latched hundreds==0.
  - Tens digit blank when latched hundreds==0 and tens==0.
  - Units digit never blanked.
  - Blank means seg=0000000 while an still selects the digit.

Test Plan:
1. Reset: hold reset=0 for 3 edges with units=5 -> tens=0, hundreds=0, flags 0, an=001, seg=0111111. Release -> display latch units becomes 5 one cycle later.
2. Cascade: drive units 0..9 repeatedly, one step per cycle, for 100 wraps -> tens increments exactly on each edge sampling 0 after 9. After 99 wraps tens=9, hundreds=9; the 100th wrap gives 000 and overflow=1, which stays set until clear.
3. Invalid input: units sequence 9,12,0 -> err=1, u_s stays 9, tens increments once at the 0. Then clear=1 together with a 9->0 carry -> tens=0, err=0, overflow=0.
4. Scan and blank: SCAN_DIV=4, count=007 -> an cycles 001,010,100, 4 cycles each. seg shows 0000111 on an=001 and 0000000 on an=010/100. With BLANK_LEADING=0 -> 0111111 on tens/hundreds.
5. Hold: count=042, hold=1, then 3 further wraps -> tens output=7, display still shows 042. Release hold -> display shows 072 after 1 cycle.
6. Mid-operation reset: assert reset=0 during a carry edge at count 099 -> all state zero on that edge, no partial increment.
